debounce_edge_fsm: RTL and testbench
====================================

DEBOUNCE_EDGE_FSM -- requirements
Module: debounce_edge_fsm

Interface
REQ-001 Parameter STABLE_CYCLES, default 20: number of consecutive stable synchronized samples required to accept a level change; legal range >= 2.
REQ-002 Parameter CNT_W, default 8: width of press_count.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sw  input  1  raw, asynchronous, bouncing switch/button input.
REQ-006 clear  input  1  synchronous clear of press_count.
REQ-007 db_level  output  1  debounced level, registered.
REQ-008 rise_tick  output  1  one-cycle pulse on accepted 0->1 change, registered.
REQ-009 fall_tick  output  1  one-cycle pulse on accepted 1->0 change, registered.
REQ-010 press_count  output  CNT_W  count of accepted rising changes, registered.

Function
REQ-011 sw SHALL pass through a 2-flop synchronizer; sync_in is the second flop's output. Only sync_in drives the FSM.
REQ-012 The FSM SHALL have four states: ZERO, WAIT1, ONE, WAIT0.
REQ-013 ZERO: sync_in=1 -> WAIT1; else stay.
REQ-014 WAIT1: sync_in=0 -> ZERO with no tick; else if timer = STABLE_CYCLES-1 -> ONE with rise; else stay.
REQ-015 ONE: sync_in=0 -> WAIT0; else stay.
REQ-016 WAIT0: sync_in=1 -> ONE with no tick; else if timer = STABLE_CYCLES-1 -> ZERO with fall; else stay.
REQ-017 Timer width: $clog2(STABLE_CYCLES). The timer SHALL be 0 on any state change and in ZERO/ONE, and increment by 1 per cycle while remaining in WAIT1/WAIT0. It never exceeds STABLE_CYCLES-1.
REQ-018 db_level, rise_tick, fall_tick and press_count SHALL be registered from next-state values, so they update on the same edge as the state register. No combinational path from sw to any output.
REQ-019 db_level SHALL be 1 when the state is ONE or WAIT0, else 0.
REQ-020 Latency: with sw sampled high at edge 0 and held, the state becomes ONE and rise_tick=1 after edge STABLE_CYCLES+2. rise_tick is high for exactly that one cycle. The falling direction is symmetric for fall_tick.
REQ-021 Bounce: a sync_in excursion shorter than STABLE_CYCLES cycles SHALL produce no tick and no db_level change. Re-entering a WAIT state restarts the timer at 0.
REQ-022 press_count SHALL increment by 1 on each rise_tick and wrap from 2^CNT_W-1 to 0.
REQ-023 If clear=1, press_count SHALL become 0 on the next edge. Clear wins over a simultaneous rise.
REQ-024 rise_tick and fall_tick SHALL never both be 1 in the same cycle.

Reset
REQ-025 On reset=1 at a clock edge, the following SHALL be set:
- state = ZERO
- timer = 0
- both synchronizer flops = 0
- db_level = 0, rise_tick = 0, fall_tick = 0
- press_count = 0
REQ-026 Reset asserted mid-WAIT1 or mid-WAIT0 SHALL abort the pending change; no tick is issued on or after that edge.
REQ-027 After reset deasserts with sw already high, the block SHALL behave as a fresh 0->1 change: rise_tick after STABLE_CYCLES+2 edges.

Structure
REQ-028 State encoding localparams (ZERO=0, WAIT1=1, ONE=2, WAIT0=3, 2 bits) SHALL live in a shared package/header so that downstream FSM stages reuse the same constants.
REQ-029 The 2-flop synchronizer SHALL be a separate sub-module named sync_2ff (ports clk, reset, d, q; synchronous active-high reset to 0).

Verification (STABLE_CYCLES=4, CNT_W=8)
REQ-030 Clean press: sw 0->1 sampled at edge 0, held -> rise_tick=1 only after edge 6; db_level=1 from edge 6; press_count=1.
REQ-031 Bounce: sw high for 3 cycles, low, then high again and held -> no tick during the glitch; a single rise_tick 6 edges after the final rise; press_count=1.
REQ-032 Release: from ONE, sw 1->0 held -> fall_tick=1 only after edge 6 relative to the sampling edge; db_level=0.
REQ-033 Wrap and clear: 256 clean presses -> press_count=0. Then 1 press -> press_count=1. Then clear coincident with the next rise_tick -> press_count=0.
REQ-034 Reset mid-operation: reset pulsed while in WAIT1 with timer=2 -> no rise_tick follows; all outputs 0. sw still high -> rise_tick 6 edges after reset deasserts.

Source files
------------

// File: rtl/debounce_edge_fsm_pkg.sv
// Shared state encoding for the debounce FSM and for any downstream FSM stages
// that need to decode its states.
package debounce_edge_fsm_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    // The level is high in ONE and while a release is still unconfirmed.
    function automatic logic level_of(input state_t s);
        return (s == ONE) || (s == WAIT0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer that brings the asynchronous switch into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make meta and q two separate flops; with
    // blocking assignments d would fall straight through to q in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debounce_edge_fsm.sv
// Debounces a raw switch, reports accepted edges as one-cycle ticks and counts presses.
module debounce_edge_fsm
    import debounce_edge_fsm_pkg::*;
#(
    parameter int STABLE_CYCLES = 20,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sw,
    input  logic             clear,
    output logic             db_level,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] press_count
);

    localparam int TIMER_W = $clog2(STABLE_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STABLE_CYCLES - 1);

    logic               sync_in;
    state_t             state, state_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic               rise_next, fall_next;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw),
        .q     (sync_in)
    );

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        timer_next = '0;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        unique case (state)
            ZERO: if (sync_in) state_next = WAIT1;
            WAIT1: begin
                if (!sync_in) begin
                    state_next = ZERO;
                end else if (timer == TIMER_LAST) begin
                    state_next = ONE;
                    rise_next  = 1'b1;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            ONE: if (!sync_in) state_next = WAIT0;
            WAIT0: begin
                if (sync_in) begin
                    state_next = ONE;
                end else if (timer == TIMER_LAST) begin
                    state_next = ZERO;
                    fall_next  = 1'b1;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: state_next = ZERO;
        endcase
    end

    // Outputs are registered from next-state values so they move with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ZERO;
            timer       <= '0;
            db_level    <= 1'b0;
            rise_tick   <= 1'b0;
            fall_tick   <= 1'b0;
            press_count <= '0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            db_level  <= level_of(state_next);
            rise_tick <= rise_next;
            fall_tick <= fall_next;
            if (clear) begin
                press_count <= '0;
            end else if (rise_next) begin
                press_count <= press_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_debounce_edge_fsm.sv
// Directed bench for debounce_edge_fsm with STABLE_CYCLES=4, CNT_W=8.
module tb_debounce_edge_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw;
    logic       clear;
    logic       db_level;
    logic       rise_tick;
    logic       fall_tick;
    logic [7:0] press_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debounce_edge_fsm #(
        .STABLE_CYCLES (4),
        .CNT_W         (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw),
        .clear       (clear),
        .db_level    (db_level),
        .rise_tick   (rise_tick),
        .fall_tick   (fall_tick),
        .press_count (press_count)
    );

    // One rising edge, then return to the falling edge to drive and sample.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold_high();
        sw = 1'b1;
        repeat (8) step();
    endtask

    task automatic hold_low();
        sw = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sw    = 1'b0;
        clear = 1'b0;
        repeat (3) step();
        checks++;
        if ({db_level, rise_tick, fall_tick} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {db_level, rise_tick, fall_tick});
        end
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", press_count);
        end
        reset = 1'b0;
        repeat (4) step();
        checks++;
        if ({db_level, rise_tick, fall_tick} !== 3'b000) begin
            errors++;
            $display("FAIL idle_flags: got %b expected 000", {db_level, rise_tick, fall_tick});
        end
    endtask

    // sw sampled high at edge 0: rise_tick only after edge 6.
    task automatic test_clean_press();
        sw = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            step();
            checks++;
            if (rise_tick !== (e == 6)) begin
                errors++;
                $display("FAIL press_rise e%0d: got %b expected %b", e, rise_tick, (e == 6));
            end
            checks++;
            if (db_level !== (e >= 6)) begin
                errors++;
                $display("FAIL press_level e%0d: got %b expected %b", e, db_level, (e >= 6));
            end
            checks++;
            if (fall_tick !== 1'b0) begin
                errors++;
                $display("FAIL press_nofall e%0d: got %b expected 0", e, fall_tick);
            end
        end
        checks++;
        if (press_count !== 8'd1) begin
            errors++;
            $display("FAIL press_count: got %0d expected 1", press_count);
        end
    endtask

    task automatic test_release();
        sw = 1'b0;
        for (int e = 0; e <= 7; e++) begin
            step();
            checks++;
            if (fall_tick !== (e == 6)) begin
                errors++;
                $display("FAIL release_fall e%0d: got %b expected %b", e, fall_tick, (e == 6));
            end
            checks++;
            if (db_level !== (e < 6)) begin
                errors++;
                $display("FAIL release_level e%0d: got %b expected %b", e, db_level, (e < 6));
            end
            checks++;
            if (rise_tick !== 1'b0) begin
                errors++;
                $display("FAIL release_norise e%0d: got %b expected 0", e, rise_tick);
            end
        end
        checks++;
        if (press_count !== 8'd1) begin
            errors++;
            $display("FAIL release_count: got %0d expected 1", press_count);
        end
    endtask

    // High for edges 0-2, low at edge 3, high from edge 4: single rise after edge 10.
    task automatic test_bounce();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int e = 0; e <= 11; e++) begin
            sw = (e != 3);
            step();
            checks++;
            if (rise_tick !== (e == 10)) begin
                errors++;
                $display("FAIL bounce_rise e%0d: got %b expected %b", e, rise_tick, (e == 10));
            end
            checks++;
            if (db_level !== (e >= 10)) begin
                errors++;
                $display("FAIL bounce_level e%0d: got %b expected %b", e, db_level, (e >= 10));
            end
            checks++;
            if (fall_tick !== 1'b0) begin
                errors++;
                $display("FAIL bounce_nofall e%0d: got %b expected 0", e, fall_tick);
            end
        end
        checks++;
        if (press_count !== 8'd1) begin
            errors++;
            $display("FAIL bounce_count: got %0d expected 1", press_count);
        end
        hold_low();
    endtask

    task automatic test_wrap_and_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL clear_idle: got %0d expected 0", press_count);
        end
        for (int p = 0; p < 256; p++) begin
            hold_high();
            hold_low();
        end
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected 0", press_count);
        end
        hold_high();
        checks++;
        if (press_count !== 8'd1) begin
            errors++;
            $display("FAIL after_wrap_count: got %0d expected 1", press_count);
        end
        hold_low();
        sw = 1'b1;
        repeat (6) step();
        checks++;
        if (rise_tick !== 1'b0) begin
            errors++;
            $display("FAIL clear_pre_rise: got %b expected 0", rise_tick);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (rise_tick !== 1'b1) begin
            errors++;
            $display("FAIL clear_rise: got %b expected 1", rise_tick);
        end
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL clear_wins: got %0d expected 0", press_count);
        end
        step();
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL clear_hold: got %0d expected 0", press_count);
        end
        hold_low();
    endtask

    // Reset at edge 5 (WAIT1, timer=2); with sw still high the rise lands after edge 12.
    task automatic test_reset_mid();
        sw = 1'b1;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({db_level, rise_tick, fall_tick} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_flags: got %b expected 000", {db_level, rise_tick, fall_tick});
        end
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL midreset_count: got %0d expected 0", press_count);
        end
        for (int e = 6; e <= 13; e++) begin
            step();
            checks++;
            if (rise_tick !== (e == 12)) begin
                errors++;
                $display("FAIL midreset_rise e%0d: got %b expected %b", e, rise_tick, (e == 12));
            end
            checks++;
            if (db_level !== (e >= 12)) begin
                errors++;
                $display("FAIL midreset_level e%0d: got %b expected %b", e, db_level, (e >= 12));
            end
            checks++;
            if (fall_tick !== 1'b0) begin
                errors++;
                $display("FAIL midreset_nofall e%0d: got %b expected 0", e, fall_tick);
            end
        end
        checks++;
        if (press_count !== 8'd1) begin
            errors++;
            $display("FAIL midreset_final_count: got %0d expected 1", press_count);
        end
    endtask

    initial begin
        reset = 1'b1;
        sw    = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_wrap_and_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
